// File: rtl/im_boot_loader_pkg.sv
// Shared sizes, FSM state encoding and count-byte helpers for the IM boot loader.
package im_boot_loader_pkg;

    localparam int IM_DEPTH  = 128;
    localparam int OP_W      = 7;
    localparam int LIT_W     = 8;
    localparam int IM_WORD_W = OP_W + LIT_W;
    localparam int IM_ADDR_W = $clog2(IM_DEPTH);
    localparam int CNT_W     = IM_ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // A count byte of zero stands for a full memory image.
    function automatic logic [CNT_W-1:0] count_words(input logic [7:0] b);
        return (b == 8'd0) ? CNT_W'(IM_DEPTH) : b;
    endfunction

    function automatic logic count_bad(input logic [7:0] b);
        return b > 8'(IM_DEPTH);
    endfunction

endpackage

// File: rtl/im_boot_loader_word_assembler.sv
// Pairs an opcode (HI) byte with a literal (LO) byte into one IM word; flags a HI byte
// with bit 7 set. word_valid pulses the cycle after the LO byte is taken.
module im_boot_loader_word_assembler
    import im_boot_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hi_take,
    input  logic                 lo_take,
    input  logic [LIT_W-1:0]     data,
    output logic                 hi_fault,
    output logic [IM_WORD_W-1:0] word,
    output logic                 word_valid
);

    logic [OP_W-1:0] hi_q;

    assign hi_fault = hi_take & data[LIT_W-1];

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            hi_q       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= lo_take;
            if (hi_take) hi_q <= data[OP_W-1:0];
            if (lo_take) word <= {hi_q, data};
        end
    end

endmodule

// File: rtl/im_boot_loader.sv
// Boot-time IM programmer: byte stream in, 15-bit words written from address 0 upward.
// Define IM_LOADER_CHECKSUM_EN to require a trailing checksum byte per session.
module im_boot_loader
    import im_boot_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic [IM_ADDR_W-1:0] pc,
    output logic [IM_ADDR_W-1:0] im_addr,
    output logic                 im_we,
    output logic [IM_WORD_W-1:0] im_wdata,
    output logic                 cpu_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     words_loaded
);

    state_t               state, state_next;
    logic [IM_ADDR_W-1:0] wptr;
    logic [CNT_W-1:0]     word_count;
    logic                 accept, session_start, hi_take, lo_take, hi_fault, last_word;
    logic                 csum_ok;

    assign rx_ready      = state inside {ST_COUNT, ST_HI, ST_LO, ST_CHK};
    assign accept        = rx_valid & rx_ready;
    assign hi_take       = accept && (state == ST_HI);
    assign lo_take       = accept && (state == ST_LO);
    assign session_start = start && (state inside {ST_IDLE, ST_DONE, ST_ERR});
    assign last_word     = (words_loaded + CNT_W'(1)) == word_count;

    // The final write lands one cycle after the FSM leaves LO, so busy covers it.
    assign busy    = rx_ready | im_we;
    assign done    = (state == ST_DONE) && !im_we;
    assign err     = (state == ST_ERR);
    assign cpu_rst = busy | err;
    assign im_addr = busy ? wptr : pc;

`ifdef IM_LOADER_CHECKSUM_EN
    localparam state_t LAST_NEXT = ST_CHK;
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (rst)                            csum <= 8'd0;
        else if (accept && state == ST_COUNT) csum <= rx_data;
        else if (accept)                    csum <= csum + rx_data;
    end

    assign csum_ok = (csum + rx_data) == 8'd0;
`else
    localparam state_t LAST_NEXT = ST_DONE;
    assign csum_ok = 1'b1;
`endif

    im_boot_loader_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .hi_take    (hi_take),
        .lo_take    (lo_take),
        .data       (rx_data),
        .hi_fault   (hi_fault),
        .word       (im_wdata),
        .word_valid (im_we)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (start)  state_next = ST_COUNT;
            ST_COUNT:                 if (accept) state_next = count_bad(rx_data) ? ST_ERR : ST_HI;
            ST_HI:                    if (accept) state_next = hi_fault ? ST_ERR : ST_LO;
            ST_LO:                    if (accept) state_next = last_word ? LAST_NEXT : ST_HI;
            ST_CHK:                   if (accept) state_next = csum_ok ? ST_DONE : ST_ERR;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // NOTE: only loader bookkeeping is reset; the IM itself keeps its image across rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            words_loaded <= '0;
            word_count   <= '0;
        end else if (session_start) begin
            wptr         <= '0;
            words_loaded <= '0;
        end else begin
            if (im_we) begin
                wptr         <= wptr + IM_ADDR_W'(1);
                words_loaded <= words_loaded + CNT_W'(1);
            end
            if (accept && state == ST_COUNT) word_count <= count_words(rx_data);
        end
    end

endmodule

// File: tb/tb_im_boot_loader.sv
// Scoreboard bench for im_boot_loader: a stream-level model predicts IM writes and the
// session outcome; a negedge monitor compares every write strobe against the queue.
module tb_im_boot_loader;

    typedef struct packed {
        logic [6:0]  addr;
        logic [14:0] data;
    } wr_t;
    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        rst, start, rx_valid, rx_ready, im_we, cpu_rst, busy, done, err;
    logic [7:0]  rx_data, words_loaded;
    logic [6:0]  pc, im_addr;
    logic [14:0] im_wdata;

    wr_t sb_q[$];
    int  lat_q[$];
    wr_t mon_e;
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    im_boot_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .pc           (pc),
        .im_addr      (im_addr),
        .im_we        (im_we),
        .im_wdata     (im_wdata),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every write must match the oldest predicted write and follow its LO byte by one cycle.
    always @(negedge clk) begin
        if (im_we) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("write_addr", 32'(im_addr), 32'(mon_e.addr));
                check("write_data", 32'(im_wdata), 32'(mon_e.data));
                check("write_busy", 32'(busy), 1);
            end
            if (lat_q.size() == 0) check("write_without_lo", 1, 0);
            else                   check("write_latency", 32'(cyc), 32'(lat_q.pop_front()));
        end
    end

    // Stream-level reference: predicts writes, bytes consumed, outcome and word count.
    task automatic model(input bytes_t s, output int used, output bit bad, output int nw);
        int         n;
        logic [7:0] hi, lo;
`ifdef IM_LOADER_CHECKSUM_EN
        logic [7:0] sum;
`endif
        used = 1;
        bad  = 1'b0;
        nw   = 0;
        if (s[0] > 8'd128) begin
            bad = 1'b1;
            return;
        end
        n = (s[0] == 8'd0) ? 128 : int'(s[0]);
        for (int i = 0; i < n; i++) begin
            hi = s[used];
            used++;
            if (hi[7]) begin
                bad = 1'b1;
                return;
            end
            lo = s[used];
            used++;
            sb_q.push_back(wr_t'{addr: 7'(i), data: {hi[6:0], lo}});
            nw++;
        end
`ifdef IM_LOADER_CHECKSUM_EN
        sum = 8'd0;
        for (int j = 0; j <= used; j++) sum = sum + s[j];
        used++;
        bad = (sum != 8'd0);
`endif
    endtask

    // Called right after a posedge (+1); returns right after the accepting posedge (+1).
    task automatic send_byte(input logic [7:0] b, input int gap, input bit is_lo);
        bit acc;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            if (acc && is_lo) lat_q.push_back(cyc);
        end
        rx_valid = 1'b0;
        check("rx_accept", 32'(acc), 1);
    endtask

    task automatic start_pulse(input bit with_valid, input logic [7:0] b);
        start = 1'b1;
        if (with_valid) begin
            rx_valid = 1'b1;
            rx_data  = b;
        end
        @(negedge clk);
        if (with_valid) check("start_byte_not_taken", 32'(rx_ready), 0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic run_session(input bytes_t data, input int delta, input bit with_valid,
                               input int maxgap);
        bytes_t s;
        int     used, nw;
        bit     bad;
`ifdef IM_LOADER_CHECKSUM_EN
        logic [7:0] sum;
`endif
        s = data;
`ifdef IM_LOADER_CHECKSUM_EN
        sum = 8'd0;
        foreach (data[k]) sum = sum + data[k];
        s.push_back(8'd0 - sum + 8'(delta));
`endif
        model(s, used, bad, nw);
        start_pulse(with_valid, s[0]);
        for (int j = 0; j < used; j++)
            send_byte(s[j], (j == 0) ? 0 : int'($urandom_range(0, maxgap)),
                      (j >= 2) && (j % 2 == 0) && (j <= 2 * nw));
        repeat (3) @(posedge clk);
        #1;
        pc = 7'($urandom);
        @(negedge clk);
        check("done", 32'(done), 32'(!bad));
        check("err", 32'(err), 32'(bad));
        check("busy_after", 32'(busy), 0);
        check("cpu_rst_after", 32'(cpu_rst), 32'(bad));
        check("words_loaded", 32'(words_loaded), 32'(nw));
        check("rx_ready_after", 32'(rx_ready), 0);
        check("im_addr_follows_pc", 32'(im_addr), 32'(pc));
        check("writes_all_seen", 32'(sb_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_im_addr"}, 32'(im_addr), 32'(pc));
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 0);
        check({tag, "_rx_ready"}, 32'(rx_ready), 0);
        check({tag, "_done_err"}, 32'({done, err}), 0);
        check({tag, "_busy_we"}, 32'({busy, im_we}), 0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 0);
        check({tag, "_im_wdata"}, 32'(im_wdata), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bytes_t     d;
        int         n;
        logic [7:0] h;

        // Reset with no session: the CPU runs the preloaded image.
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pc       = 7'h2A;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;

        // Two-word image; start arrives together with a valid byte in IDLE.
        d.delete();
        d.push_back(8'h02); d.push_back(8'h05); d.push_back(8'hA1);
        d.push_back(8'h7F); d.push_back(8'hFF);
        run_session(d, 0, 1'b1, 0);

        // Full 128-word image with random valid gaps.
        d.delete();
        d.push_back(8'h00);
        for (int i = 0; i < 128; i++) begin
            d.push_back(8'($urandom_range(0, 127)));
            d.push_back(8'($urandom));
        end
        run_session(d, 0, 1'b0, 2);

        // Oversized count aborts, then a good session clears the error.
        d.delete();
        d.push_back(8'h81);
        run_session(d, 0, 1'b0, 0);
        d.delete();
        d.push_back(8'h01); d.push_back(8'h12); d.push_back(8'h34);
        run_session(d, 0, 1'b0, 1);

        // Bad HI byte in word 1: only word 0 is written.
        d.delete();
        d.push_back(8'h02); d.push_back(8'h11); d.push_back(8'h22);
        d.push_back(8'h80); d.push_back(8'h44);
        run_session(d, 0, 1'b0, 1);

        // Reset in the middle of a load.
        sb_q.push_back(wr_t'{addr: 7'd0, data: {7'h11, 8'h22}});
        start_pulse(1'b0, 8'h00);
        send_byte(8'h05, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b1);
        send_byte(8'h33, 0, 1'b0);
        check("midload_busy", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("midload_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef IM_LOADER_CHECKSUM_EN
        // Checksum accepted, then a corrupted checksum after one written word.
        d.delete();
        d.push_back(8'h01); d.push_back(8'h03); d.push_back(8'h10);
        run_session(d, 0, 1'b0, 1);
        run_session(d, 1, 1'b0, 1);
`endif

        // Random sessions with occasional count, HI-bit and checksum faults.
        for (int t = 0; t < 12; t++) begin
            n = int'($urandom_range(1, 6));
            d.delete();
            if ($urandom_range(0, 5) == 0) d.push_back(8'($urandom_range(129, 255)));
            else                           d.push_back(8'(n));
            for (int i = 0; i < n; i++) begin
                h = 8'($urandom_range(0, 127));
                if ($urandom_range(0, 11) == 0) h[7] = 1'b1;
                d.push_back(h);
                d.push_back(8'($urandom));
            end
            run_session(d, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : 0,
                        1'($urandom_range(0, 1)), 3);
        end

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 0);
        check("latency_queue_empty", 32'(lat_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
